// File: rtl/spi_sniff_deserializer.sv
// spi_sniff_deserializer: passive SPI (mode 0, MSB first) sniffer. It oversamples the
// tapped bus in the clk domain, splits each CS frame into DATA_W-bit words tagged with a
// channel index, and queues them in a show-ahead FIFO drained over a valid/ready stream.
// Optional build macro SPI_WORD_TIMEOUT_EN: a partial word whose SCK stalls for
// TIMEOUT_CYC cycles is aborted (frame_err), and the rest of that frame is ignored.
module spi_sniff_deserializer #(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 256,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_miso,
  output logic [DATA_W-1:0] m_data,
  output logic [CW-1:0]     m_chan,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LW-1:0]     fifo_level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              frame_err
);

  localparam int BW = $clog2(DATA_W);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + CW;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

  // Reject unusable parameter sets at elaboration time.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (DATA_W < 2 || NUM_CH < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("DATA_W >= 2, NUM_CH >= 1, TIMEOUT_CYC >= 1 required");
  end

  // S_WAIT is the reset state: any frame already in flight is skipped until CS goes high.
  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_SHIFT, S_ABORT} state_t;

  logic [2:0] sck_q;
  logic [1:0] cs_q, miso_q;
  logic       sck_e, cs_n_s, miso_s;

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [DATA_W-2:0] sreg_q, sreg_d;
  logic [DATA_W-1:0] word;
  logic              wr_en;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] last_q;
  logic [PW-1:0] wp_q, rp_q;
  logic [LW-1:0] level_q;
  logic          ovf_q, full, push, pop, drop;

`ifdef SPI_WORD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign sck_e  = sck_q[1] & ~sck_q[2];
  assign cs_n_s = cs_q[1];
  assign miso_s = miso_q[1];
  assign word   = {sreg_q, miso_s};

  // Two-flop synchronisers; the third SCK flop provides rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= '0;
      cs_q   <= '0;
      miso_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_q   <= {cs_q[0], spi_cs_n};
      miso_q <= {miso_q[0], spi_miso};
    end
  end

  // Deserializer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      bit_q   <= '0;
      wcnt_q  <= '0;
      sreg_q  <= '0;
`ifdef SPI_WORD_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      wcnt_q  <= wcnt_d;
      sreg_q  <= sreg_d;
`ifdef SPI_WORD_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Next state: shift on SCK rise, emit the word on its last bit, abort partial words.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    wcnt_d  = wcnt_q;
    sreg_d  = sreg_q;
    wr_en   = 1'b0;
`ifdef SPI_WORD_TIMEOUT_EN
    tmo_d   = '0;
`endif
    case (state_q)
      S_WAIT: begin
        bit_d  = '0;
        wcnt_d = '0;
        if (cs_n_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        bit_d  = '0;
        wcnt_d = '0;
        if (!cs_n_s) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (sck_e) begin
          sreg_d = word[DATA_W-2:0];
          if (bit_q == BIT_LAST) begin
            wr_en  = 1'b1;
            bit_d  = '0;
            wcnt_d = (wcnt_q == CH_LAST) ? '0 : wcnt_q + 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
`ifdef SPI_WORD_TIMEOUT_EN
        tmo_d = sck_e ? '0 : ((tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1);
`endif
        // A CS rise coinciding with the final bit still lands the word (bit_d is 0).
        if (cs_n_s) state_d = (bit_d == '0) ? S_IDLE : S_ABORT;
`ifdef SPI_WORD_TIMEOUT_EN
        else if (!sck_e && tmo_q == TMO_MAX && bit_q != '0) state_d = S_ABORT;
`endif
      end
      S_ABORT: begin
        bit_d   = '0;
        wcnt_d  = '0;
        state_d = cs_n_s ? S_IDLE : S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  assign frame_err = (state_q == S_ABORT);

  assign full = (level_q == LW'(FIFO_DEPTH));
  assign pop  = m_valid & m_ready;
  assign push = wr_en & (~full | pop);
  assign drop = wr_en & full & ~pop;

  // FIFO storage; entries are only read once written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {word, wcnt_q};
  end

  // FIFO pointers, level, sticky overflow and the last-popped hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) begin
        rp_q   <= rp_q + 1'b1;
        last_q <= mem_q[rp_q];
      end
      level_q <= level_q + LW'(push) - LW'(pop);
      ovf_q   <= drop | (ovf_q & ~ovf_clr);
    end
  end

  assign m_valid           = (level_q != '0);
  assign {m_data, m_chan}  = m_valid ? mem_q[rp_q] : last_q;
  assign fifo_level        = level_q;
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_spi_sniff_deserializer.sv
// Randomized self-checking bench for spi_sniff_deserializer (default parameters).
// Expected words come from a queue model: frame word index mod NUM_CH gives the channel,
// and a word is kept only while fewer than FIFO_DEPTH words are outstanding.
module tb_spi_sniff_deserializer;
  localparam int DW = 16, NCH = 3, DEPTH = 8;

  logic        clk = 1'b0, rst_n, spi_sck, spi_cs_n, spi_miso, m_ready, ovf_clr;
  logic [15:0] m_data;
  logic [1:0]  m_chan;
  logic        m_valid, overflow, frame_err;
  logic [3:0]  fifo_level;

  int n_cmp = 0, n_bad = 0;
  int fe_cnt = 0, widx = 0;
  bit rnd_rdy = 0, exp_ovf = 0, prev_stall = 0;
  logic [31:0] prev_word;
  logic [31:0] exp_q[$], got_q[$];

  spi_sniff_deserializer dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
    .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: collect beats, check stall stability, count frame_err.
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall && m_valid) chk("stable", 32'({m_chan, m_data}), prev_word);
      if (m_valid && m_ready) got_q.push_back(32'({m_chan, m_data}));
      if (frame_err) fe_cnt++;
      prev_stall = m_valid & ~m_ready;
      prev_word  = 32'({m_chan, m_data});
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    spi_miso = b; spi_sck = 1'b0; cyc(4);
    spi_sck = 1'b1; cyc(4);
    spi_sck = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) spi_bit(w[15-i]);
  endtask

  task automatic model_word(input logic [15:0] w);
    if (exp_q.size() - got_q.size() < DEPTH) exp_q.push_back({14'b0, 2'(widx % NCH), w});
    else exp_ovf = 1;
    widx++;
  endtask

  // pop_last: raise m_ready for exactly the cycle in which the last bit's word is written.
  task automatic send_word(input logic [15:0] w, input bit pop_last);
    send_bits(w, DW - 1);
    spi_miso = w[0]; spi_sck = 1'b0; cyc(4);
    spi_sck = 1'b1;
    if (pop_last) begin
      cyc(2); m_ready = 1'b1; cyc(1); m_ready = 1'b0; cyc(1);
    end else cyc(4);
    spi_sck = 1'b0;
    model_word(w);
  endtask

  task automatic frame_begin();
    spi_cs_n = 1'b0; widx = 0; cyc(4);
  endtask

  task automatic frame_end();
    cyc(4); spi_cs_n = 1'b1; cyc(8);
  endtask

  task automatic drain_check(input string tag);
    int n = 0;
    m_ready = 1'b1;
    while (got_q.size() < exp_q.size() && n < 400) begin cyc(1); n++; end
    cyc(4);
    chk({tag, "_cnt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
    chk({tag, "_lvl"}, 32'(fifo_level), 0);
    m_ready = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(m_data), 0);
    chk({tag, "_chan"}, 32'(m_chan), 0);
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_lvl"}, 32'(fifo_level), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_ferr"}, 32'(frame_err), 0);
  endtask

  initial begin
    int fe0, nw, tail, fe_exp;
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_miso = 1'b0;
    m_ready = 1'b0; ovf_clr = 1'b0;
    cyc(3);
    chk_zero("rst");
    rst_n = 1'b1; cyc(6);

    // 1: one frame of three known words, streaming
    fe0 = fe_cnt; m_ready = 1'b1;
    frame_begin();
    send_word(16'hA55A, 0); send_word(16'h1234, 0); send_word(16'hFFFF, 0);
    frame_end();
    drain_check("t1");
    chk("t1_ferr", fe_cnt - fe0, 0);

    // 2: consumer stalled, ten words -> eight kept, overflow sticky until cleared
    m_ready = 1'b0;
    frame_begin();
    for (int i = 0; i < 10; i++) send_word(16'($urandom), 0);
    frame_end();
    chk("t2_lvl", 32'(fifo_level), DEPTH);
    chk("t2_ovf", 32'(overflow), 32'(exp_ovf));
    drain_check("t2");
    chk("t2_last", 32'(m_data), 32'(prev_word[15:0]));
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0; exp_ovf = 0; cyc(1);
    chk("t2_clr", 32'(overflow), 32'(exp_ovf));

    // 3: CS rises after 7 bits of the second word; next frame restarts at chan 0
    fe0 = fe_cnt; m_ready = 1'b1;
    frame_begin();
    send_word(16'($urandom), 0);
    send_bits(16'($urandom), 7);
    frame_end();
    chk("t3_ferr", fe_cnt - fe0, 1);
    frame_begin();
    send_word(16'($urandom), 0); send_word(16'($urandom), 0);
    frame_end();
    drain_check("t3");

    // 4: FIFO full, a pop lands in the same cycle as the ninth word's write
    m_ready = 1'b0;
    frame_begin();
    for (int i = 0; i < 8; i++) send_word(16'($urandom), 0);
    send_word(16'($urandom), 1);
    chk("t4_lvl", 32'(fifo_level), DEPTH);
    chk("t4_ovf", 32'(overflow), 0);
    frame_end();
    drain_check("t4");

    // 5: reset mid-word, released with CS still low -> rest of that frame ignored
    fe0 = fe_cnt; m_ready = 1'b1;
    frame_begin();
    send_bits(16'($urandom), 5);
    rst_n = 1'b0; cyc(2);
    chk_zero("t5_rst");
    rst_n = 1'b1;
    send_bits(16'($urandom), 11);
    send_bits(16'($urandom), 16);
    frame_end();
    chk("t5_ign", got_q.size(), 0);
    frame_begin();
    send_word(16'($urandom), 0); send_word(16'($urandom), 0);
    frame_end();
    drain_check("t5");
    chk("t5_ferr", fe_cnt - fe0, 0);

    // 6: SCK stalls after 5 bits
    fe0 = fe_cnt;
    frame_begin();
    send_bits(16'($urandom), 5);
    cyc(300);
`ifdef SPI_WORD_TIMEOUT_EN
    chk("t6_tmo", fe_cnt - fe0, 1);
`else
    chk("t6_hold", fe_cnt - fe0, 0);
`endif
    spi_cs_n = 1'b1; cyc(8);
    chk("t6_ferr", fe_cnt - fe0, 1);
    frame_begin();
    send_word(16'($urandom), 0); send_word(16'($urandom), 0);
    frame_end();
    drain_check("t6");

    // Randomized frames with a random-ready consumer and occasional partial tails
    fe0 = fe_cnt; fe_exp = 0; rnd_rdy = 1;
    for (int f = 0; f < 6; f++) begin
      nw   = $urandom_range(1, 5);
      tail = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
      frame_begin();
      for (int w = 0; w < nw; w++) send_word(16'($urandom), 0);
      if (tail != 0) begin send_bits(16'($urandom), tail); fe_exp++; end
      frame_end();
    end
    rnd_rdy = 0; cyc(2);
    drain_check("rnd");
    chk("rnd_ferr", fe_cnt - fe0, fe_exp);
    chk("rnd_ovf", 32'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
